serdes_rx_channel_model: RTL
============================

Name: serdes_rx_channel_model

Overview:
- Synthesizable 64b/66b channel model between the PHY transmit serdes outputs (serdes_tx_data/serdes_tx_hdr) and the PHY receive serdes inputs (serdes_rx_data/serdes_rx_hdr).
- Applies a bit-slip misalignment that the PHY's serdes_rx_bitslip output corrects, so block-lock acquisition is exercised in hardware.
- Corrupts sync headers at a programmable random rate or in deterministic bursts, and counts blocks and corruptions for BER/lock characterisation.

Parameters:
- DATA_WIDTH, 64, payload width; only 64 is supported.
- HDR_WIDTH, 2, sync header width; only 2 is supported.
- LFSR_SEED, 32'h1, nonzero reset seed of the noise LFSR.
- INIT_OFFSET, 0, reset value of the slip offset; legal range 0..65.

Ports:
- rx_clk  in  1  single clock for all logic.
- rx_rst_n  in  1  asynchronous, active-low reset.
- in_data  in  64  block payload from the transmit serdes.
- in_hdr  in  2  sync header from the transmit serdes.
- out_data  out  64  payload toward the receive serdes input.
- out_hdr  out  2  header toward the receive serdes input.
- out_valid  out  1  high once the pipeline is filled.
- rx_bitslip  in  1  slip request from the PHY.
- cfg_ber_thresh  in  32  random corruption threshold; 0 disables random corruption.
- cfg_err_hdr  in  2  header value substituted on corruption (e.g. 2'b11).
- cfg_burst_len  in  16  number of blocks in a burst.
- cfg_burst_start  in  1  single-cycle burst trigger.
- cnt_clear  in  1  synchronous clear of both counters.
- blk_count  out  32  valid blocks emitted, saturating.
- err_count  out  32  corrupted blocks emitted, saturating.
- slip_offset  out  7  current alignment offset, 0..65.
- burst_active  out  1  high in the BURST state.

Behaviour:
- Reset values: out_data=0, out_hdr=0, out_valid=0, counters=0, slip_offset=INIT_OFFSET, lfsr=LFSR_SEED, FSM=RANDOM, burst_active=0, prev word=0.
- Word format: w={in_data,in_hdr}, 66 bits, with the header in bits [1:0] (first on the wire).
- Stage 1 registers prev<=w every cycle.
- Stage 2 registers win=({w,prev}>>slip_offset)[65:0], then out_hdr=win[1:0] and out_data=win[65:2].
- With offset 0 the output equals the input delayed exactly 2 cycles.
- out_valid rises on the 2nd rising edge after reset release and stays high.
- Bitslip: rising-edge detect on rx_bitslip, registered once.
  - Each rising edge increments slip_offset by 1, wrapping 65->0.
  - A level held high counts as one slip only.
  - The new offset applies to the stage-2 capture on the cycle after the edge is detected.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1; advances every cycle after reset and never reaches 0.
- Random hit: lfsr < cfg_ber_thresh, evaluated in the cycle stage 2 captures.
  - Threshold 0 gives no hits.
  - Threshold 32'hFFFFFFFF hits every block except when lfsr==32'hFFFFFFFF.
- Corruption replaces out_hdr with cfg_err_hdr only; out_data is never altered.
- FSM:
  - RANDOM: corruption follows random hits.
  - RANDOM -> BURST when cfg_burst_start=1 and cfg_burst_len!=0; burst_cnt loads cfg_burst_len.
  - cfg_burst_start with cfg_burst_len=0 is ignored.
  - BURST: every captured block is corrupted regardless of the LFSR, and burst_cnt decrements per block.
  - BURST -> RANDOM when the block captured with burst_cnt==1 is emitted. Exactly cfg_burst_len consecutive corrupted blocks result, the first captured the cycle after the start pulse.
  - cfg_burst_start while in BURST is ignored; no retrigger and no extension.
- Counters:
  - blk_count increments once per cycle with out_valid=1.
  - err_count increments once per emitted corrupted block with out_valid=1; blocks emitted while out_valid=0 are not counted.
  - Both saturate at 32'hFFFFFFFF.
  - cnt_clear has priority over increment; the counter value becomes 0 on that edge.
- Reset asserted mid-burst or mid-slip returns all state to reset values immediately (asynchronous); no partial burst resumes after release.
- cfg_* inputs are sampled every cycle; changing cfg_ber_thresh takes effect on the next capture.

Test Plan:
- Reset release, thresh=0, offset 0, ramp pattern in_data=N, in_hdr=2'b01 -> out equals input 2 cycles later; out_valid high from the 2nd edge; err_count stays 0; blk_count equals cycles with out_valid=1.
- One rx_bitslip pulse (then held high 8 cycles) with in_data=64'h5555..., hdr=2'b10 -> slip_offset=1 only; output equals the 66-bit stream shifted by 1 bit.
- 66 slip pulses -> slip_offset returns to 0; output identical to the unslipped stream; PHY rx_block_lock reasserts.
- thresh=32'hFFFFFFFF, cfg_err_hdr=2'b11 for 1000 blocks -> err_count >= 999; out_data unchanged.
- thresh=0, burst_len=5, single start pulse -> exactly 5 consecutive out_hdr=2'b11; err_count=5; burst_active high for 5 cycles; a second start pulse during the burst changes nothing.
- rx_rst_n low during a burst of 100 -> all outputs at reset values within the same cycle; after release burst_active=0 and err_count=0; cnt_clear concurrent with an error gives 0.

Source files
------------

// File: rtl/serdes_rx_channel_model.sv
// 64b/66b channel model: bit-slip misalignment toward the PHY receiver plus
// sync-header corruption (LFSR-random or deterministic burst) with counters.
module serdes_rx_channel_model #(
  parameter int          DATA_WIDTH  = 64,
  parameter int          HDR_WIDTH   = 2,
  parameter logic [31:0] LFSR_SEED   = 32'h1,
  parameter int          INIT_OFFSET = 0
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_hdr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [HDR_WIDTH-1:0]  out_hdr,
  output logic                  out_valid,
  input  logic                  rx_bitslip,
  input  logic [31:0]           cfg_ber_thresh,
  input  logic [HDR_WIDTH-1:0]  cfg_err_hdr,
  input  logic [15:0]           cfg_burst_len,
  input  logic                  cfg_burst_start,
  input  logic                  cnt_clear,
  output logic [31:0]           blk_count,
  output logic [31:0]           err_count,
  output logic [6:0]            slip_offset,
  output logic                  burst_active
);

  localparam int          WORD_W     = DATA_WIDTH + HDR_WIDTH;
  localparam logic [6:0]  MAX_OFFSET = 7'd65;
  localparam logic [6:0]  INIT_OFF   = 7'(INIT_OFFSET);
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

  typedef enum logic {ST_RANDOM = 1'b0, ST_BURST = 1'b1} state_t;

  // Galois step for x^32+x^22+x^2+x+1; a nonzero state never maps to zero.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    lfsr_next = {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cur);
    sat_inc = (cur == 32'hFFFF_FFFF) ? cur : cur + 32'd1;
  endfunction

  logic [WORD_W-1:0] word_s;
  logic [WORD_W-1:0] prev_r;
  logic [WORD_W-1:0] win_s;
  logic              bitslip_q_r;
  logic              slip_edge_s;
  logic [6:0]        slip_offset_r;
  logic [31:0]       lfsr_r;
  state_t            state_r;
  state_t            state_nxt_s;
  logic [15:0]       burst_cnt_r;
  logic [15:0]       burst_cnt_nxt_s;
  logic              corrupt_s;
  logic              fill_r;
  logic              out_valid_r;
  logic              out_corrupt_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [HDR_WIDTH-1:0]  out_hdr_r;
  logic [31:0]       blk_count_r;
  logic [31:0]       err_count_r;
  logic              burst_active_r;

  assign word_s      = {in_data, in_hdr};
  assign win_s       = WORD_W'({word_s, prev_r} >> slip_offset_r);
  assign slip_edge_s = rx_bitslip & ~bitslip_q_r;

  // Burst/random selection and the corruption decision for this capture.
  always_comb begin
    state_nxt_s     = state_r;
    burst_cnt_nxt_s = burst_cnt_r;
    corrupt_s       = 1'b0;
    case (state_r)
      ST_RANDOM: begin
        corrupt_s = (lfsr_r < cfg_ber_thresh);
        if (cfg_burst_start && (cfg_burst_len != 16'd0)) begin
          state_nxt_s     = ST_BURST;
          burst_cnt_nxt_s = cfg_burst_len;
        end else begin
          state_nxt_s = ST_RANDOM;
        end
      end
      ST_BURST: begin
        corrupt_s       = 1'b1;
        burst_cnt_nxt_s = burst_cnt_r - 16'd1;
        if (burst_cnt_r == 16'd1) begin
          state_nxt_s = ST_RANDOM;
        end else begin
          state_nxt_s = ST_BURST;
        end
      end
      default: begin
        state_nxt_s     = ST_RANDOM;
        burst_cnt_nxt_s = 16'd0;
      end
    endcase
  end

  // FSM state, noise source and slip alignment.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_r        <= ST_RANDOM;
      burst_cnt_r    <= 16'd0;
      burst_active_r <= 1'b0;
      lfsr_r         <= LFSR_SEED;
      bitslip_q_r    <= 1'b0;
      slip_offset_r  <= INIT_OFF;
    end else begin
      state_r        <= state_nxt_s;
      burst_cnt_r    <= burst_cnt_nxt_s;
      burst_active_r <= (state_nxt_s == ST_BURST);
      lfsr_r         <= lfsr_next(lfsr_r);
      bitslip_q_r    <= rx_bitslip;
      if (slip_edge_s) begin
        slip_offset_r <= (slip_offset_r == MAX_OFFSET) ? 7'd0 : slip_offset_r + 7'd1;
      end
    end
  end

  // Two-stage datapath: previous word, then shifted window with header substitution.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      prev_r        <= '0;
      fill_r        <= 1'b0;
      out_valid_r   <= 1'b0;
      out_corrupt_r <= 1'b0;
      out_data_r    <= '0;
      out_hdr_r     <= '0;
    end else begin
      prev_r        <= word_s;
      fill_r        <= 1'b1;
      out_valid_r   <= fill_r;
      out_corrupt_r <= corrupt_s;
      out_data_r    <= win_s[WORD_W-1:HDR_WIDTH];
      out_hdr_r     <= corrupt_s ? cfg_err_hdr : win_s[HDR_WIDTH-1:0];
    end
  end

  // Counters look at the block currently on the outputs; clear wins over count.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      blk_count_r <= 32'd0;
      err_count_r <= 32'd0;
    end else if (cnt_clear) begin
      blk_count_r <= 32'd0;
      err_count_r <= 32'd0;
    end else begin
      if (out_valid_r) begin
        blk_count_r <= sat_inc(blk_count_r);
      end
      if (out_valid_r && out_corrupt_r) begin
        err_count_r <= sat_inc(err_count_r);
      end
    end
  end

  assign out_data     = out_data_r;
  assign out_hdr      = out_hdr_r;
  assign out_valid    = out_valid_r;
  assign blk_count    = blk_count_r;
  assign err_count    = err_count_r;
  assign slip_offset  = slip_offset_r;
  assign burst_active = burst_active_r;

endmodule
